xcalc_unit: RTL and testbench

Memory-mapped, parametrised signed arithmetic coprocessor for the calculator SoC: it replaces the fixed 4-bit combinational ALU and the separate two's-complement unpacking stage. The controller writes two signed operands and a command over the internal data bus, polls a status word, and reads a double-width result. Multiply and divide are iterative, and a busy/done handshake exposes their latency. Result and flags are also brought out as ports for the display decoder.

---
 rtl/xcalc_unit.sv | 207 ++++++++++++++++++++
 tb/tb_xcalc_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xcalc_unit.sv
// xcalc_unit: memory-mapped signed add/sub/mul/div coprocessor.
// Optional divider datapath: define XCALC_DIV_EN to build it.
module xcalc_unit #(
   parameter int OP_W  = 8,
   parameter int BUS_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sel,
   input  logic               we,
   input  logic [1:0]         addr,
   input  logic [BUS_W-1:0]   data_in,
   output logic [BUS_W-1:0]   data_out,
   output logic [2*OP_W-1:0]  result,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int RW = 2 * OP_W;
   localparam int CW = $clog2(OP_W);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t          state, state_nx;
   logic [OP_W-1:0] opa, opb, a_q, b_q;
   logic [1:0]      op_q;
   logic [CW-1:0]   cnt;
   logic [RW-1:0]   acc, x;
   logic [OP_W-1:0] y;
   logic            done_sticky, ovf;
   logic            wr, start, last, long_op;
   logic [OP_W:0]   ea, eb, sum;
   logic [RW-1:0]   acc_mul;
   logic [RW-1:0]   res_nx;
   logic            err_nx, ovf_nx;
   logic            unused_bits;

`ifdef XCALC_DIV_EN
   logic [OP_W:0]   shf, dif;
   logic [OP_W-1:0] rem_nx, quo_nx, q_s, r_s;
`endif

   function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
      return v[OP_W-1] ? -v : v;
   endfunction

   assign unused_bits = ^data_in[BUS_W-1:OP_W];
   assign wr          = sel & we;
   assign start       = wr && (addr == 2'd2) && (state != RUN);
   assign last        = (cnt == '0);

   // Ops that iterate one bit per cycle get OP_W cycles in RUN.
   always_comb begin
      long_op = (data_in[1:0] == 2'd2);
`ifdef XCALC_DIV_EN
      long_op = long_op | (data_in[1:0] == 2'd3);
`endif
   end

   // FSM state register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // FSM next state plus busy/done decode.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = FIN;
         end
         FIN: begin
            done     = 1'b1;
            state_nx = start ? RUN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Shift-add multiplier step on magnitudes.
   always_comb acc_mul = acc + (y[0] ? x : '0);

`ifdef XCALC_DIV_EN
   // Restoring divider step: rem in acc low half, quotient shifts into y.
   always_comb begin
      shf = {acc[OP_W-1:0], y[OP_W-1]};
      dif = shf - {1'b0, x[OP_W-1:0]};
      if (!dif[OP_W]) begin
         rem_nx = dif[OP_W-1:0];
         quo_nx = {y[OP_W-2:0], 1'b1};
      end else begin
         rem_nx = shf[OP_W-1:0];
         quo_nx = {y[OP_W-2:0], 1'b0};
      end
      q_s = (a_q[OP_W-1] ^ b_q[OP_W-1]) ? -quo_nx : quo_nx;
      r_s = a_q[OP_W-1] ? -rem_nx : rem_nx;
   end
`endif

   // Value committed to result/err/ovf on the last RUN cycle.
   always_comb begin
      ea     = {a_q[OP_W-1], a_q};
      eb     = {b_q[OP_W-1], b_q};
      sum    = op_q[0] ? ea - eb : ea + eb;
      res_nx = '0;
      err_nx = 1'b0;
      ovf_nx = 1'b0;
      unique case (op_q)
         2'd0, 2'd1: begin
            res_nx = RW'($signed(sum));
            ovf_nx = sum[OP_W] ^ sum[OP_W-1];
         end
         2'd2: begin
            res_nx = (a_q[OP_W-1] ^ b_q[OP_W-1]) ? -acc_mul : acc_mul;
         end
         default: begin
`ifdef XCALC_DIV_EN
            if (b_q == '0) begin
               err_nx = 1'b1;
            end else begin
               res_nx = {r_s, q_s};
               ovf_nx = (a_q == {1'b1, {(OP_W-1){1'b0}}}) && (&b_q);
            end
`else
            err_nx = 1'b1;
`endif
         end
      endcase
   end

   // Bus registers, operand capture, iteration and commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opa         <= '0;
         opb         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         cnt         <= '0;
         acc         <= '0;
         x           <= '0;
         y           <= '0;
         result      <= '0;
         err         <= 1'b0;
         ovf         <= 1'b0;
         done_sticky <= 1'b0;
      end else begin
         if (wr && addr == 2'd0) opa <= data_in[OP_W-1:0];
         if (wr && addr == 2'd1) opb <= data_in[OP_W-1:0];
         if (start) begin
            op_q        <= data_in[1:0];
            a_q         <= opa;
            b_q         <= opb;
            acc         <= '0;
            done_sticky <= 1'b0;
            cnt         <= long_op ? CW'(OP_W - 1) : '0;
            if (data_in[1:0] == 2'd3) begin
               x <= RW'(mag(opb));
               y <= mag(opa);
            end else begin
               x <= RW'(mag(opa));
               y <= mag(opb);
            end
         end else if (state == RUN) begin
            if (!last) cnt <= cnt - 1'b1;
            if (op_q == 2'd2) begin
               acc <= acc_mul;
               x   <= x << 1;
               y   <= y >> 1;
            end
`ifdef XCALC_DIV_EN
            else if (op_q == 2'd3) begin
               acc <= RW'(rem_nx);
               y   <= quo_nx;
            end
`endif
            if (last) begin
               result      <= res_nx;
               err         <= err_nx;
               ovf         <= ovf_nx;
               done_sticky <= 1'b1;
            end
         end
      end
   end

   // Zero-wait register read mux.
   always_comb begin
      data_out = '0;
      if (sel) begin
         unique case (addr)
            2'd0:    data_out = BUS_W'($signed(opa));
            2'd1:    data_out = BUS_W'($signed(opb));
            2'd2:    data_out = BUS_W'({result[RW-1], ovf, err,
                                        done_sticky, busy});
            default: data_out = BUS_W'($signed(result));
         endcase
      end
   end

endmodule

// File: tb/tb_xcalc_unit.sv
// tb_xcalc_unit: directed checks of xcalc_unit at OP_W=8, BUS_W=32.
// Division vectors are used when XCALC_DIV_EN is defined.
module tb_xcalc_unit;

   logic        clk, rst, sel, we;
   logic [1:0]  addr;
   logic [31:0] data_in, data_out;
   logic [15:0] result;
   logic        busy, done, err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;

`ifdef XCALC_DIV_EN
   localparam logic [31:0] LONG_OP = 32'd3;
`else
   localparam logic [31:0] LONG_OP = 32'd2;
`endif

   xcalc_unit #(.OP_W(8), .BUS_W(32)) dut (
      .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
      .data_in(data_in), .data_out(data_out), .result(result),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; data_in = d;
      @(negedge clk);
      sel = 1'b0; we = 1'b0; data_in = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a,
                         input logic [31:0] exp);
      sel = 1'b1; we = 1'b0; addr = a;
      #1 chk(tag, data_out, exp);
      @(negedge clk);
      sel = 1'b0;
   endtask

   task automatic start_op(input string tag, input logic [31:0] op);
      start_cyc = cyc;
      wr(2'd2, op);
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input string tag, input int lat);
      while (done !== 1'b1 && (cyc - start_cyc) < 40) @(negedge clk);
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      chk({tag, " lat"}, cyc - start_cyc, lat);
   endtask

   initial begin
      rst = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
      #1;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst err", {31'd0, err}, 32'd0);
      chk("rst result", {16'd0, result}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rd_chk("rst opa", 2'd0, 32'd0);
      rd_chk("rst opb", 2'd1, 32'd0);
      rd_chk("rst status", 2'd2, 32'd0);
      rd_chk("rst res", 2'd3, 32'd0);

      // 100 + 50 = 150, overflows 8-bit signed
      wr(2'd0, 32'd100);
      wr(2'd1, 32'd50);
      start_op("add", 32'd0);
      wait_done("add", 2);
      chk("add result", {16'd0, result}, 32'h0000_0096);
      @(negedge clk);
      chk("add done pulse", {31'd0, done}, 32'd0);
      rd_chk("add status", 2'd2, 32'h0000_000A);
      rd_chk("add res rd", 2'd3, 32'h0000_0096);

      // -5 - 3 = -8
      wr(2'd0, 32'h0000_00FB);
      wr(2'd1, 32'd3);
      start_op("sub", 32'd1);
      wait_done("sub", 2);
      chk("sub result", {16'd0, result}, 32'h0000_FFF8);
      rd_chk("sub status", 2'd2, 32'h0000_0012);
      rd_chk("sub res rd", 2'd3, 32'hFFFF_FFF8);

      // -7 * 9, with ignored CTRL write and OPA write while busy
      wr(2'd0, 32'h0000_00F9);
      wr(2'd1, 32'd9);
      start_op("mul", 32'd2);
      rd_chk("mul mid status", 2'd2, 32'h0000_0011);
      wr(2'd2, 32'd0);
      wr(2'd0, 32'd2);
      wait_done("mul", 9);
      chk("mul result", {16'd0, result}, 32'h0000_FFC1);
      // back-to-back start at the done cycle picks up new OPA=2
      start_op("mul2", 32'd2);
      wait_done("mul2", 9);
      chk("mul2 result", {16'd0, result}, 32'h0000_0012);
      rd_chk("mul2 status", 2'd2, 32'h0000_0002);

      // -128 * -128 = 16384
      wr(2'd0, 32'h0000_0080);
      wr(2'd1, 32'h0000_0080);
      start_op("mulmin", 32'd2);
      wait_done("mulmin", 9);
      chk("mulmin result", {16'd0, result}, 32'h0000_4000);
      rd_chk("mulmin status", 2'd2, 32'h0000_0002);

`ifdef XCALC_DIV_EN
      // -17 / 5 = -3 rem -2
      wr(2'd0, 32'h0000_00EF);
      wr(2'd1, 32'd5);
      start_op("div", 32'd3);
      wait_done("div", 9);
      chk("div result", {16'd0, result}, 32'h0000_FEFD);
      chk("div err", {31'd0, err}, 32'd0);
      // 10 / 0
      wr(2'd0, 32'd10);
      wr(2'd1, 32'd0);
      start_op("div0", 32'd3);
      wait_done("div0", 9);
      chk("div0 result", {16'd0, result}, 32'd0);
      chk("div0 err", {31'd0, err}, 32'd1);
      // -128 / -1
      wr(2'd0, 32'h0000_0080);
      wr(2'd1, 32'h0000_00FF);
      start_op("divovf", 32'd3);
      wait_done("divovf", 9);
      chk("divovf result", {16'd0, result}, 32'h0000_0080);
      rd_chk("divovf status", 2'd2, 32'h0000_000A);
`else
      // op 3 without a divider: error at add/sub latency
      wr(2'd0, 32'd10);
      wr(2'd1, 32'd0);
      start_op("nodiv", 32'd3);
      wait_done("nodiv", 2);
      chk("nodiv result", {16'd0, result}, 32'd0);
      chk("nodiv err", {31'd0, err}, 32'd1);
      rd_chk("nodiv status", 2'd2, 32'h0000_0006);
`endif

      // err clears on the next good op
      wr(2'd0, 32'd20);
      wr(2'd1, 32'd22);
      start_op("add2", 32'd0);
      wait_done("add2", 2);
      chk("add2 result", {16'd0, result}, 32'h0000_002A);
      chk("add2 err", {31'd0, err}, 32'd0);

      // reset in cycle T+4 of a long op
      @(negedge clk);
      start_op("abort", LONG_OP);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort result", {16'd0, result}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort no done", {31'd0, done}, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort post done", {31'd0, done}, 32'd0);
      rd_chk("abort opa", 2'd0, 32'd0);
      rd_chk("abort status", 2'd2, 32'd0);

      // normal op after the abort
      wr(2'd0, 32'd3);
      wr(2'd1, 32'd4);
      start_op("add3", 32'd0);
      wait_done("add3", 2);
      chk("add3 result", {16'd0, result}, 32'h0000_0007);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
